data_mem_ext: RTL and testbench

//   Parametrised data memory for the single-cycle core. Byte-addressed,

---
 rtl/data_mem_ext.sv | 148 ++++++++++++++
 tb/tb_data_mem_ext.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ext.sv
// data_mem_ext: byte-addressed little-endian data memory with byte/half/word
// access, sign/zero-extended loads, a one-word-per-cycle clear sweep after
// reset, and misalign / out-of-range detection with a sticky store fault.
module data_mem_ext #(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 32,
    parameter int TEST_IDX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       WD,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [31:0]       RD,
    output logic              ready,
    output logic              misalign,
    output logic              oob,
    output logic              fault,
    output logic [15:0]       test_value
);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIDX_W = ADDR_W - 2;
    // DEPTH expressed at full word-index width so upper address bits are
    // compared too and never alias into the array.
    localparam logic [WIDX_W-1:0] DEPTH_W  = WIDX_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     clr_ptr_q, clr_ptr_d;
    logic                 fault_q, fault_d;
    logic [31:0]          mem_q [DEPTH];

    logic [1:0]           lane;
    logic [IDX_W-1:0]     word_idx;
    logic                 acc_ok;
    logic [31:0]          rd_word;
    logic [7:0]           rd_byte;
    logic [15:0]          rd_half;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [3:0]           wr_mask;
    logic [31:0]          wr_data;

    assign lane     = A[1:0];
    assign word_idx = A[IDX_W+1:2];
    assign oob      = (A[ADDR_W-1:2] >= DEPTH_W);
    assign acc_ok   = ~misalign & ~oob;
    assign ready    = (state_q == S_RUN);
    assign fault    = fault_q;
    assign test_value = mem_q[TEST_IDX][15:0];

    // Alignment check; reserved size 11 behaves as a word access.
    always_comb begin
        misalign = 1'b0;
        case (size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = A[0];
            default: misalign = (A[1:0] != 2'b00);
        endcase
    end

    // Combinational load: pick lane(s) and extend; zero outside RUN or on a bad access.
    always_comb begin
        rd_word = mem_q[word_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = A[1] ? rd_word[31:16] : rd_word[15:0];
        RD      = 32'h0;
        if (state_q == S_RUN && acc_ok) begin
            case (size)
                2'b00:   RD = uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                2'b01:   RD = uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
                default: RD = rd_word;
            endcase
        end
    end

    // Next-state, sweep pointer, fault and write-port control.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        fault_d   = fault_q;
        wr_en     = 1'b0;
        wr_idx    = word_idx;
        wr_mask   = 4'h0;
        wr_data   = 32'h0;
        case (state_q)
            S_INIT: begin
                // Clear one word per cycle; stores are ignored until done.
                wr_en     = 1'b1;
                wr_idx    = clr_ptr_q;
                wr_mask   = 4'hF;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_IDX) state_d = S_RUN;
            end
            S_RUN: begin
                if (we) begin
                    if (acc_ok) begin
                        wr_en = 1'b1;
                        case (size)
                            2'b00: begin
                                wr_mask = 4'b0001 << lane;
                                wr_data = {4{WD[7:0]}};
                            end
                            2'b01: begin
                                wr_mask = A[1] ? 4'b1100 : 4'b0011;
                                wr_data = {2{WD[15:0]}};
                            end
                            default: begin
                                wr_mask = 4'hF;
                                wr_data = WD;
                            end
                        endcase
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Control registers; reset restarts the sweep from word 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_INIT;
            clr_ptr_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            fault_q   <= fault_d;
        end
    end

    // Storage array with per-byte-lane write enables; no reset, cleared by the sweep.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ext.sv
// tb_data_mem_ext: randomized + directed stimulus against a byte-array
// reference model; expected responses are queued by the driver and
// compared by an independent monitor on the falling edge.
module tb_data_mem_ext;
    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 32;
    localparam int TEST_IDX = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] A   = '0;
    logic [31:0]       WD  = '0;
    logic              we  = 1'b0;
    logic [1:0]        size = 2'b10;
    logic              uns = 1'b0;
    logic [31:0]       RD;
    logic              ready, misalign, oob, fault;
    logic [15:0]       test_value;

    always #5 clk = ~clk;

    data_mem_ext #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TEST_IDX(TEST_IDX)) dut (
        .clk(clk), .rst(rst), .A(A), .WD(WD), .we(we), .size(size), .uns(uns),
        .RD(RD), .ready(ready), .misalign(misalign), .oob(oob), .fault(fault),
        .test_value(test_value)
    );

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        rdy;
        logic        mis;
        logic        ob;
        logic        flt;
        logic        tv_chk;
        logic [15:0] tv;
    } exp_t;

    exp_t sb[$];
    logic chk_vld = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Reference model: flat byte array, cycles left in the clear sweep, fault flag.
    logic [7:0] mbytes [4*DEPTH];
    int         init_left;
    logic       m_fault;

    function automatic logic m_mis(logic [31:0] a, logic [1:0] sz);
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    endfunction

    function automatic logic m_oob(logic [31:0] a);
        return (a / 4) >= DEPTH;
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] a, logic [1:0] sz, logic u);
        int          base = int'(a >> 2) * 4;
        int          hb   = base + 2 * int'(a[1]);
        logic [7:0]  b;
        logic [15:0] h;
        if (sz == 2'b00) begin
            b = mbytes[base + int'(a[1:0])];
            return u ? {24'h0, b} : {{24{b[7]}}, b};
        end
        if (sz == 2'b01) begin
            h = {mbytes[hb+1], mbytes[hb]};
            return u ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return {mbytes[base+3], mbytes[base+2], mbytes[base+1], mbytes[base]};
    endfunction

    function automatic void cmp(string nm, string fld, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, req);
        end
    endfunction

    // Monitor: every presented cycle pops one expectation and compares outputs.
    always @(negedge clk) begin
        exp_t e;
        if (chk_vld) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                e = sb.pop_front();
                cmp(e.name, "RD", RD, e.rd);
                cmp(e.name, "ready", {31'h0, ready}, {31'h0, e.rdy});
                cmp(e.name, "misalign", {31'h0, misalign}, {31'h0, e.mis});
                cmp(e.name, "oob", {31'h0, oob}, {31'h0, e.ob});
                cmp(e.name, "fault", {31'h0, fault}, {31'h0, e.flt});
                if (e.tv_chk) cmp(e.name, "test_value", {16'h0, test_value}, {16'h0, e.tv});
            end
        end
    end

    // One bus cycle: present inputs, queue expectation, then advance model past the edge.
    task automatic cyc(string nm, logic [31:0] a, logic [31:0] wd, logic w,
                       logic [1:0] sz, logic u);
        exp_t e;
        logic mis, ob, rdy;
        int   base, hb;
        A = a; WD = wd; we = w; size = sz; uns = u;
        mis = m_mis(a, sz);
        ob  = m_oob(a);
        rdy = (init_left == 0);
        e.name   = nm;
        e.mis    = mis;
        e.ob     = ob;
        e.rdy    = rdy;
        e.flt    = m_fault;
        e.rd     = (!rdy || mis || ob) ? 32'h0 : m_load(a, sz, u);
        e.tv_chk = rdy;
        e.tv     = {mbytes[4*TEST_IDX+1], mbytes[4*TEST_IDX]};
        sb.push_back(e);
        chk_vld = 1'b1;
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        if (!rdy) begin
            init_left--;
        end else if (w) begin
            if (mis || ob) begin
                m_fault = 1'b1;
            end else begin
                base = int'(a >> 2) * 4;
                hb   = base + 2 * int'(a[1]);
                if (sz == 2'b00) begin
                    mbytes[base + int'(a[1:0])] = wd[7:0];
                end else if (sz == 2'b01) begin
                    mbytes[hb]   = wd[7:0];
                    mbytes[hb+1] = wd[15:8];
                end else begin
                    for (int i = 0; i < 4; i++) mbytes[base+i] = wd[8*i +: 8];
                end
            end
        end
    endtask

    // Hold reset low for n edges, release just after an edge.
    task automatic do_reset(int n);
        chk_vld = 1'b0;
        we  = 1'b0;
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
        init_left = DEPTH;
        m_fault   = 1'b0;
        for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'h0;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return $urandom | 32'h1000_0000;
        if (r == 1) return 32'(4*DEPTH) + $urandom_range(0, 15);
        return 32'($urandom_range(0, 4*DEPTH-1));
    endfunction

    initial begin
        int wait_cnt;
        // Reset, then sweep with stray stores (including we at A=0, WD=0xFFFF).
        do_reset(2);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 3) cyc("init_store0", 32'h0, 32'h0000_FFFF, 1'b1, 2'b10, 1'b0);
            else cyc("init", rnd_addr(), $urandom, 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        cyc("lw0_after_init", 32'h0, 32'h0, 1'b0, 2'b10, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc("zero_sweep", 32'(4*i), 32'h0, 1'b0, 2'b10, 1'b0);

        // Word store, byte loads with sign/zero extension.
        cyc("sw8", 32'd8, 32'h8765_4321, 1'b1, 2'b10, 1'b0);
        cyc("lb9", 32'd9, 32'h0, 1'b0, 2'b00, 1'b0);
        cyc("lb11", 32'd11, 32'h0, 1'b0, 2'b00, 1'b0);
        cyc("lbu11", 32'd11, 32'h0, 1'b0, 2'b00, 1'b1);
        cyc("lh10", 32'd10, 32'h0, 1'b0, 2'b01, 1'b0);

        // Half store into upper lanes of a word.
        cyc("sw0", 32'd0, 32'h1111_1111, 1'b1, 2'b10, 1'b0);
        cyc("sh2", 32'd2, 32'h0000_BEEF, 1'b1, 2'b01, 1'b0);
        cyc("lw0", 32'd0, 32'h0, 1'b0, 2'b10, 1'b0);
        cyc("lhu2", 32'd2, 32'h0, 1'b0, 2'b01, 1'b1);

        // Dropped stores: misaligned and out of range.
        cyc("sw_mis", 32'd6, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b0);
        cyc("sw_oob", 32'(4*DEPTH), 32'hCAFE_F00D, 1'b1, 2'b10, 1'b0);
        cyc("lw4", 32'd4, 32'h0, 1'b0, 2'b10, 1'b0);
        cyc("lw_oob", 32'(4*DEPTH), 32'h0, 1'b0, 2'b10, 1'b0);
        cyc("lw_hi", 32'h8000_0000, 32'h0, 1'b0, 2'b10, 1'b0);

        // Reset pulse in the middle of a sweep restarts it.
        do_reset(1);
        for (int i = 0; i < DEPTH/2; i++) cyc("sweep_a", rnd_addr(), $urandom, 1'b1, 2'b10, 1'b0);
        do_reset(1);
        for (int i = 0; i < DEPTH + 2; i++) cyc("sweep_b", rnd_addr(), $urandom, 1'b0, 2'b10, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset(1);
            cyc("rand", rnd_addr(), $urandom, ($urandom_range(0, 9) < 4),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
